add_subtract: RTL and testbench
===============================

ADD_SUBTRACT -- requirements
Module: add_subtract

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits; legal range 2..64.
REQ-002 Parameter DELAY, default 0.05 (ns), propagation delay of each inverter in the datapath; simulation-only, no effect on synthesis.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low (0 = reset asserted).
REQ-005 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-007 addSub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 in_valid  input  1  operands and addSub are sampled this cycle.
REQ-009 sum  output  WIDTH  registered result.
REQ-010 cout  output  1  registered carry out of the MSB.
REQ-011 overflow  output  1  registered signed overflow.
REQ-012 zero  output  1  registered flag, 1 when sum is all zeros.
REQ-013 negative  output  1  registered copy of sum[WIDTH-1].
REQ-014 out_valid  output  1  registered; 1 in the cycle after in_valid was 1.

Function
REQ-015 Datapath is a WIDTH-bit ripple-carry chain of full_adder cells (sum = a^b^cin, cout = majority(a,b,cin)), one per bit.
REQ-016 Each bit selects its B input via a mux2_1 cell: in[0] = b[i], in[1] = ~b[i], sel = addSub.
REQ-017 Bit 0 carry-in is addSub; bit i carry-in is carry-out of bit i-1.
REQ-018 addSub=0: result = (a + b) mod 2^WIDTH; addSub=1: result = (a + ~b + 1) mod 2^WIDTH = (a - b) mod 2^WIDTH.
REQ-019 cout = carry out of bit WIDTH-1; for subtract, cout=1 means no borrow (a >= b unsigned).
REQ-020 overflow = carry into MSB XOR carry out of MSB.
REQ-021 zero and negative derive from the combinational result in the same cycle it is registered.
REQ-022 Latency exactly 1 cycle: when in_valid=1 at edge N, sum/flags reflect those inputs after edge N and out_valid=1 until edge N+1.
REQ-023 When in_valid=0 at an edge, sum, cout, overflow, zero, negative hold their previous values; out_valid goes 0.
REQ-024 No handshake backpressure; a new operation is accepted every cycle, back-to-back in_valid produces back-to-back out_valid.
REQ-025 Wrap-around is silent: no saturation, result always modulo 2^WIDTH.
REQ-026 Changing addSub between cycles affects only the operation sampled in that cycle.

Reset
REQ-027 When reset=0 at a rising clk edge: sum=0, cout=0, overflow=0, zero=1, negative=0, out_valid=0.
REQ-028 Reset has priority over in_valid; an operation presented in a reset cycle is discarded.
REQ-029 Reset asserted mid-stream clears outputs on that edge; first result after release requires a fresh in_valid.
REQ-030 Outputs are undefined only before the first clock edge; no asynchronous clearing.

Verification
REQ-031 WIDTH=3, exhaustive a,b in 0..7 for addSub=0 then addSub=1, one op per cycle -> each sum equals (a+b) mod 8 or (a-b) mod 8 one cycle later, out_valid=1 throughout.
REQ-032 WIDTH=64, a=0xFFFFFFFFFFFFFFFF, b=1, addSub=0 -> sum=0, cout=1, zero=1, overflow=0.
REQ-033 WIDTH=64, a=0x7FFFFFFFFFFFFFFF, b=1, addSub=0 -> sum=0x8000000000000000, overflow=1, negative=1, cout=0.
REQ-034 WIDTH=64, a=5, b=7, addSub=1 -> sum=0xFFFFFFFFFFFFFFFE, cout=0, negative=1; a=7,b=5 -> sum=2, cout=1.
REQ-035 Result held after in_valid drops, then reset=0 for one edge -> sum=0, zero=1, out_valid=0; in_valid with reset=0 produces no result.

Source files
------------

// File: rtl/add_subtract_if.sv
// Operand/result bundle for add_subtract: the stimulus side drives operands, the datapath side returns registered results.
interface add_subtract_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             addSub;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             out_valid;

    modport master (
        output a, b, addSub, in_valid,
        input  sum, cout, overflow, zero, negative, out_valid
    );

    modport slave (
        input  a, b, addSub, in_valid,
        output sum, cout, overflow, zero, negative, out_valid
    );
endinterface

// File: rtl/add_subtract.sv
// Ripple-carry adder/subtractor built from mux2_1 and full_adder cells, with a one-cycle registered result and flags.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module mux2_1 (
    input  logic [1:0] in,
    input  logic       sel,
    output logic       out
);
    assign out = in[sel];
endmodule

module add_subtract #(
    parameter int unsigned WIDTH = 64,
    parameter real         DELAY = 0.05
) (
    input  logic          clk,
    input  logic          reset,
    add_subtract_if.slave bus
);
    // Reject out-of-range configurations at elaboration.
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("add_subtract: WIDTH must be in 2..64");
    end
    if (DELAY < 0.0) begin : g_bad_delay
        $error("add_subtract: DELAY must be non-negative");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] result_c;

    // Subtraction is a + ~b + 1: the inverted b comes from the mux, the +1 from the initial carry.
    assign carry[0] = bus.addSub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic b_sel;

        mux2_1 u_mux (
            .in  ({~bus.b[i], bus.b[i]}),
            .sel (bus.addSub),
            .out (b_sel)
        );

        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (b_sel),
            .cin  (carry[i]),
            .s    (result_c[i]),
            .cout (carry[i+1])
        );
    end

    // Result and flags load only on accepted operations and hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b1;
            bus.negative  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum      <= result_c;
                bus.cout     <= carry[WIDTH];
                bus.overflow <= carry[WIDTH] ^ carry[WIDTH-1];
                bus.zero     <= (result_c == '0);
                bus.negative <= result_c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_add_subtract.sv
// Scoreboard bench for add_subtract: a 3-bit instance swept exhaustively and a 64-bit instance with directed and random operands.
module tb_add_subtract;

    typedef struct {
        logic        v;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    exp_t q64[$];
    exp_t q3[$];
    exp_t last64;
    exp_t last3;

    add_subtract_if #(.WIDTH(64)) bus64 ();
    add_subtract_if #(.WIDTH(3))  bus3 ();

    add_subtract #(.WIDTH(64), .DELAY(0.05)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    add_subtract #(.WIDTH(3), .DELAY(0.05)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Reference: plain modular arithmetic and sign rules for a w-bit operation.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub);
        exp_t        e;
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] r;
        logic        sa, sb, sr;
        mask = (65'd1 << w) - 65'd1;
        full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r    = 64'(full & mask);
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = r[w-1];
        e.v    = 1'b1;
        e.sum  = r;
        e.cout = sub ? (a >= b) : full[w];
        e.ovf  = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        e.zero = (r == 64'd0);
        e.neg  = sr;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.v = 1'b0; e.sum = 64'd0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b1; e.neg = 1'b0;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle on both instances and queue what each should show after the next edge.
    task automatic cycle(input logic rst_n,
                         input logic v64, input logic [63:0] a64, input logic [63:0] b64, input logic s64,
                         input logic v3, input logic [2:0] a3, input logic [2:0] b3, input logic s3);
        exp_t e;
        @(negedge clk);
        reset          = rst_n;
        bus64.in_valid = v64; bus64.a = a64; bus64.b = b64; bus64.addSub = s64;
        bus3.in_valid  = v3;  bus3.a  = a3;  bus3.b  = b3;  bus3.addSub  = s3;

        if (!rst_n)   e = reset_exp();
        else if (v64) e = model(64, a64, b64, s64);
        else begin    e = last64; e.v = 1'b0; end
        last64 = e;
        q64.push_back(e);

        if (!rst_n)  e = reset_exp();
        else if (v3) e = model(3, 64'(a3), 64'(b3), s3);
        else begin   e = last3; e.v = 1'b0; end
        last3 = e;
        q3.push_back(e);
    endtask

    task automatic idle64(input logic rst_n, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic s);
        cycle(rst_n, v, a, b, s, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    // Monitors: each cycle the registered outputs are compared against the oldest queued expectation.
    initial begin : mon64
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q64.size() > 0) begin
                e = q64.pop_front();
                chk("w64 out_valid", 64'(bus64.out_valid), 64'(e.v));
                chk("w64 sum",       bus64.sum,            e.sum);
                chk("w64 cout",      64'(bus64.cout),      64'(e.cout));
                chk("w64 overflow",  64'(bus64.overflow),  64'(e.ovf));
                chk("w64 zero",      64'(bus64.zero),      64'(e.zero));
                chk("w64 negative",  64'(bus64.negative),  64'(e.neg));
            end else if (bus64.out_valid === 1'b1) begin
                chk("w64 unexpected out_valid", 64'(bus64.out_valid), 64'd0);
            end
        end
    end

    initial begin : mon3
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("w3 out_valid", 64'(bus3.out_valid), 64'(e.v));
                chk("w3 sum",       64'(bus3.sum),       e.sum);
                chk("w3 cout",      64'(bus3.cout),      64'(e.cout));
                chk("w3 overflow",  64'(bus3.overflow),  64'(e.ovf));
                chk("w3 zero",      64'(bus3.zero),      64'(e.zero));
                chk("w3 negative",  64'(bus3.negative),  64'(e.neg));
            end else if (bus3.out_valid === 1'b1) begin
                chk("w3 unexpected out_valid", 64'(bus3.out_valid), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b0;
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.addSub = 1'b0;
        bus3.in_valid  = 1'b0; bus3.a  = '0; bus3.b  = '0; bus3.addSub  = 1'b0;
        last64 = reset_exp();
        last3  = reset_exp();

        repeat (2) idle64(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);

        // Exhaustive 3-bit sweep, add then subtract, back to back; 64-bit instance gets random traffic.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    cycle(1'b1, ($urandom_range(0, 3) != 0), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                          1'b1, 3'(a), 3'(b), 1'(s));

        // Directed 64-bit boundary cases.
        idle64(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        idle64(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        idle64(1'b1, 1'b1, 64'd5, 64'd7, 1'b1);
        idle64(1'b1, 1'b1, 64'd7, 64'd5, 1'b1);
        idle64(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        idle64(1'b1, 1'b1, 64'd9, 64'd9, 1'b1);

        // Hold after in_valid drops, then a reset cycle that must discard a presented operation.
        repeat (3) idle64(1'b1, 1'b0, 64'd1, 64'd2, 1'b0);
        cycle(1'b0, 1'b1, 64'd3, 64'd4, 1'b0, 1'b1, 3'd3, 3'd2, 1'b0);
        repeat (2) idle64(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, 64'd10, 64'd3, 1'b1, 1'b1, 3'd1, 3'd7, 1'b0);

        // Random mixed traffic with occasional idle and reset cycles.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 30) != 0),
                  ($urandom_range(0, 4) != 0), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));

        idle64(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("w64 scoreboard drained", 64'(q64.size()), 64'd0);
        chk("w3 scoreboard drained",  64'(q3.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
